// File: rtl/fsk_pkg.sv
// Shared 2FSK constants: default symbol window length, decision threshold and counter width.
// The modulator bench uses the same values for its frequency-ratio constants.
package fsk_pkg;

   localparam int unsigned SYM_LEN_DEF  = 48;
   localparam int unsigned EDGE_THR_DEF = 6;
   localparam int unsigned CNT_W_DEF    = 8;

   typedef enum logic {
      BIT_LOW  = 1'b0,
      BIT_HIGH = 1'b1
   } fsk_bit_e;

endpackage

// File: rtl/fsk_edge_sync.sv
// Two-flop synchronizer for the asynchronous FSK input, plus a history flop
// that turns each synchronized rising edge into a single-cycle pulse.
module fsk_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic rise_out
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_out = s2 & ~s3;

endmodule

// File: rtl/fsk_decode.sv
// Non-coherent 2FSK demodulator: counts input rising edges over free-running
// symbol windows and decides each bit by comparing the count with a threshold.
module fsk_decode
   import fsk_pkg::*;
#(
   parameter int unsigned SYM_LEN  = SYM_LEN_DEF,
   parameter int unsigned EDGE_THR = EDGE_THR_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fsk_in,
   output logic             code_out,
   output logic             code_valid,
   output logic [CNT_W-1:0] edge_cnt_out
);

   localparam int unsigned WIN_W = $clog2(SYM_LEN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYM_LEN - 1);
   localparam logic [CNT_W-1:0] THR      = CNT_W'(EDGE_THR);

   logic             rise;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] total;

   fsk_edge_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .d_in     (fsk_in),
      .rise_out (rise)
   );

   // Running count including this cycle's edge, held at all-ones once full.
   always_comb begin
      total = edge_cnt;
      if (rise && (edge_cnt != '1)) begin
         total = edge_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt      <= '0;
         edge_cnt     <= '0;
         code_out     <= 1'b0;
         code_valid   <= 1'b0;
         edge_cnt_out <= '0;
      end else begin
         code_valid <= 1'b0;
         if (!en) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
         end else if (win_cnt == WIN_LAST) begin
            code_out     <= (total > THR) ? BIT_HIGH : BIT_LOW;
            edge_cnt_out <= total;
            code_valid   <= 1'b1;
            win_cnt      <= '0;
            edge_cnt     <= '0;
         end else begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= total;
         end
      end
   end

endmodule

// File: tb/tb_fsk_decode.sv
// Scoreboard bench for fsk_decode: a default-width instance and a 3-bit saturating
// instance share one randomized stimulus stream and are checked against a cycle-level model.
module tb_fsk_decode;
   import fsk_pkg::*;

   localparam int SL = 48;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       fsk_in = 1'b0;
   logic       code_a, valid_a;
   logic [7:0] cnt_a;
   logic       code_b, valid_b;
   logic [2:0] cnt_b;

   fsk_decode #(.SYM_LEN(SL), .EDGE_THR(6), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .en(en), .fsk_in(fsk_in),
      .code_out(code_a), .code_valid(valid_a), .edge_cnt_out(cnt_a)
   );

   fsk_decode #(.SYM_LEN(SL), .EDGE_THR(5), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .en(en), .fsk_in(fsk_in),
      .code_out(code_b), .code_valid(valid_b), .edge_cnt_out(cnt_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int cnt;
      int cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   passes = 0;
   int   cyc = 0;
   bit   armed = 1'b0;
   int   thr[2]  = '{6, 5};
   int   maxc[2] = '{255, 7};
   int   pos[2]    = '{0, 0};
   int   ecount[2] = '{0, 0};
   int   hcode[2]  = '{0, 0};
   int   hcnt[2]   = '{0, 0};
   bit   h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
   int   ph = 0;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   // Reference: an input rise is counted 3 posedges after it is driven; windows
   // count true edges with an unbounded integer, clipped only at the decision.
   always @(posedge clk) begin : model
      bit   rise;
      int   tot;
      exp_t e;
      cyc++;
      rise = h1 & ~h2;
      if (rst) begin
         h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
         armed = 1'b1;
      end else begin
         h2 = h1; h1 = h0; h0 = fsk_in;
      end
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            pos[i] = 0; ecount[i] = 0; hcode[i] = 0; hcnt[i] = 0;
         end else if (!en) begin
            pos[i] = 0; ecount[i] = 0;
         end else begin
            ecount[i] += int'(rise);
            if (pos[i] == SL - 1) begin
               tot    = (ecount[i] > maxc[i]) ? maxc[i] : ecount[i];
               e.code = (tot > thr[i]) ? 1 : 0;
               e.cnt  = tot;
               e.cyc  = cyc;
               hcode[i] = e.code;
               hcnt[i]  = tot;
               if (i == 0) qa.push_back(e);
               else qb.push_back(e);
               pos[i] = 0;
               ecount[i] = 0;
            end else begin
               pos[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (armed) begin
         if (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            chk("a_valid", int'(valid_a), 1);
            chk("a_strobe_cycle", cyc, e.cyc);
            chk("a_code", int'(code_a), e.code);
            chk("a_edge_cnt", int'(cnt_a), e.cnt);
         end else begin
            chk("a_valid", int'(valid_a), 0);
            chk("a_code_hold", int'(code_a), hcode[0]);
            chk("a_cnt_hold", int'(cnt_a), hcnt[0]);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (armed) begin
         if (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            chk("b_valid", int'(valid_b), 1);
            chk("b_strobe_cycle", cyc, e.cyc);
            chk("b_code", int'(code_b), e.code);
            chk("b_edge_cnt", int'(cnt_b), e.cnt);
         end else begin
            chk("b_valid", int'(valid_b), 0);
            chk("b_code_hold", int'(code_b), hcode[1]);
            chk("b_cnt_hold", int'(cnt_b), hcnt[1]);
         end
      end
   end

   task automatic sq(int period, int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         fsk_in = ((ph % period) < (period / 2)) ? 1'b1 : 1'b0;
         ph++;
      end
   endtask

   task automatic pat7(int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         fsk_in = ((ph % SL) % 7 < 3) ? 1'b1 : 1'b0;
         ph++;
      end
   endtask

   task automatic noise(int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         fsk_in = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic wait_pos(int target);
      for (int k = 0; k < 2 * SL && pos[0] != target; k++) @(negedge clk);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      ph  = 0;
      sq(4, 3 * SL);
      sq(12, 3 * SL);
      fsk_in = 1'b0;
      repeat (2 * SL) @(negedge clk);
      sq(8, 3 * SL);
      pat7(3 * SL);
      wait_pos(20);
      en = 1'b0;
      sq(4, 10);
      en = 1'b1;
      sq(4, 2 * SL);
      wait_pos(SL - 1);
      en = 1'b0;
      sq(4, 3);
      en = 1'b1;
      sq(4, SL + 5);
      wait_pos(30);
      rst = 1'b1;
      sq(4, 1);
      rst = 1'b0;
      sq(4, 2 * SL);
      sq(2, 3 * SL);
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 5))
            0:       noise($urandom_range(10, 120));
            1: begin en = 1'b0; sq(4, $urandom_range(1, 15)); en = 1'b1; end
            2: begin rst = 1'b1; sq(3, $urandom_range(1, 3)); rst = 1'b0; end
            default: sq($urandom_range(2, 20), $urandom_range(10, 150));
         endcase
      end
      sq(6, 2 * SL);
      en = 1'b0;
      repeat (SL + 5) @(negedge clk);
      chk("a_queue_drained", qa.size(), 0);
      chk("b_queue_drained", qb.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fsk_decode.md
Name: fsk_decode

Overview:
Non-coherent 2FSK demodulator, directly downstream of the 2FSK modulator.
- Input is the modulator's square-wave output, sampled by a faster system clock.
- Counts rising edges of that input over fixed symbol windows and decides each bit by frequency: high frequency gives 1, low frequency gives 0.
- Emits the recovered serial code with a one-cycle valid strobe per symbol, for the downstream code sink or bit-error checker.

Parameters:
SYM_LEN, 48, clk cycles per symbol window; must be >= 2.
EDGE_THR, 6, decision threshold; bit = 1 when the window edge count is > EDGE_THR.
CNT_W, 8, width of the edge counter and of edge_cnt_out; EDGE_THR < 2^CNT_W-1.

Ports:
clk  input  1  system/sample clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
en  input  1  demodulation enable; low holds the window logic idle.
fsk_in  input  1  FSK square wave, asynchronous to clk.
code_out  output  1  last decided bit.
code_valid  output  1  one-cycle strobe, high when code_out updates.
edge_cnt_out  output  CNT_W  edge count of the last completed window.

Behaviour:
- Reset (sync, active-high, checked on posedge clk):
  - Clears synchronizer flops, win_cnt, edge_cnt, code_out, code_valid and edge_cnt_out to 0.
  - rst has priority over every other input.
  - Reset mid-window discards the partial window; no strobe is produced.
- Input conditioning:
  - fsk_in passes through a 2-flop synchronizer plus one history flop (s1, s2, s3).
  - edge = s2 & ~s3.
  - An input rising edge is seen as edge 3 cycles later, at the posedge where it has reached s2.
- Window counter win_cnt (0..SYM_LEN-1):
  - Increments each cycle while en=1 and wraps to 0 after SYM_LEN-1.
  - The first cycle en is sampled high is window cycle 0.
- Edge counter edge_cnt:
  - Adds edge each cycle while en=1.
  - Saturates at 2^CNT_W-1 and never wraps.
- Window end (en=1 and win_cnt==SYM_LEN-1):
  - total = sat(edge_cnt + edge). An edge on the last cycle belongs to the ending window.
  - Next cycle: code_out = (total > EDGE_THR), edge_cnt_out = total, code_valid = 1, edge_cnt = 0, win_cnt = 0.
  - Strobes are exactly SYM_LEN cycles apart in steady state.
- code_valid is 0 on every other cycle.
- code_out and edge_cnt_out hold their values between strobes.
- en=0:
  - Next cycle win_cnt=0 and edge_cnt=0; the partial window is discarded with no strobe.
  - code_out and edge_cnt_out hold; the synchronizer keeps running.
  - If en falls on the window-end cycle, no strobe is produced.
- Tie rule: total == EDGE_THR decodes as 0.
- No symbol-timing recovery: windows are free-running from en rise. Alignment to modulator symbol boundaries is the system's responsibility.

Decomposition:
- Package fsk_pkg: default SYM_LEN, EDGE_THR and CNT_W constants; shared with the modulator bench for ratio constants.
- Sub-module fsk_edge_sync: 2-flop synchronizer plus history flop plus rising-edge pulse; ports clk, rst, d_in, rise_out.
- Top-level contents: window counter, edge counter and decision register.

Test Plan:
- Rate 1, aligned: rst 4 cycles, then en=1 with fsk_in period 4 clk (12 edges/window) -> code_valid every 48 cycles, code_out=1, edge_cnt_out=12.
- Rate 0: fsk_in period 12 clk -> edge_cnt_out=4, code_out=0. Then constant fsk_in=0 -> edge_cnt_out=0, code_out=0, strobes still every 48 cycles.
- Threshold tie: exactly 6 rising edges in a window -> code_out=0. With 7 edges -> code_out=1.
- Boundary edge: edge reaches s2 on window cycle 47 -> counted in the current window; on cycle 0 of the next window -> counted in the next window.
- Interruptions:
  - en dropped at window cycle 20 and raised 10 cycles later -> no strobe for the partial window, code_out holds, next strobe 48 cycles after en rise.
  - rst at cycle 30 -> all outputs 0 next cycle.
- Saturation (CNT_W=3, EDGE_THR=5, fsk_in period 2 clk) -> edge_cnt_out=7, code_out=1, no wrap.
